// File: rtl/vidsync_axis.sv
// rtl/vidsync_axis.sv - one raster axis: position counter with wrap, sync window and active window
module vidsync_axis #(
  parameter int NBITS = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_step,
  input  logic             i_clear,
  input  logic [NBITS-1:0] i_m,
  input  logic [NBITS-1:0] i_s,
  input  logic [NBITS-1:0] i_e,
  input  logic [NBITS-1:0] i_t,
  output logic [NBITS-1:0] o_pos,
  output logic             o_wrap,
  output logic             o_sync,
  output logic             o_active
);

  localparam logic [NBITS-1:0] ONE = {{(NBITS-1){1'b0}}, 1'b1};

  logic [NBITS-1:0] pos_q, pos_d;
  logic             last;

  // A zero total or a position already past the end both force a wrap.
  assign last = (i_t == '0) || (pos_q >= i_t - ONE);

  always_comb begin
    pos_d = pos_q;
    if (i_clear)
      pos_d = '0;
    else if (i_step)
      pos_d = last ? '0 : pos_q + ONE;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      pos_q <= '0;
    else
      pos_q <= pos_d;
  end

  assign o_pos    = pos_q;
  assign o_wrap   = i_step && last;
  assign o_sync   = (pos_q >= i_s) && (pos_q < i_e);
  assign o_active = pos_q < i_m;

endmodule

// File: rtl/vidsyncgen.sv
// rtl/vidsyncgen.sv - video timing generator with shadowed timing, sync pulses, data enable and frame marker
module vidsyncgen #(
  parameter int   NBITS = 16,
  parameter logic HPOL  = 1'b1,
  parameter logic VPOL  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [NBITS-1:0] i_hm,
  input  logic [NBITS-1:0] i_hs,
  input  logic [NBITS-1:0] i_he,
  input  logic [NBITS-1:0] i_ht,
  input  logic [NBITS-1:0] i_vm,
  input  logic [NBITS-1:0] i_vs,
  input  logic [NBITS-1:0] i_ve,
  input  logic [NBITS-1:0] i_vt,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [NBITS-1:0] o_x,
  output logic [NBITS-1:0] o_y,
  output logic             o_frame,
  output logic             o_err
);

  localparam logic HS_ON = HPOL;
  localparam logic VS_ON = VPOL;

  function automatic logic timing_ok(input logic [NBITS-1:0] m, s, e, t);
    return (m != '0) && (m <= s) && (s < e) && (e <= t);
  endfunction

  logic [NBITS-1:0] hm_q, hs_q, he_q, ht_q, vm_q, vs_q, ve_q, vt_q;
  logic             valid_q, valid_d;
  logic             run, capture;

  logic [NBITS-1:0] h_pos, v_pos;
  logic             h_wrap, h_sync, h_act;
  logic             v_wrap, v_sync, v_act;

  logic [NBITS-1:0] x_q, x_d, y_q, y_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             de_q, de_d, frame_q, frame_d, err_q, err_d;

  assign run     = i_en && valid_q;
  // Shadows track the inputs except while a frame is in progress.
  assign capture = !run || v_wrap;
  assign valid_d = timing_ok(hm_q, hs_q, he_q, ht_q) && timing_ok(vm_q, vs_q, ve_q, vt_q);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hm_q    <= '0;
      hs_q    <= '0;
      he_q    <= '0;
      ht_q    <= '0;
      vm_q    <= '0;
      vs_q    <= '0;
      ve_q    <= '0;
      vt_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      if (capture) begin
        hm_q <= i_hm;
        hs_q <= i_hs;
        he_q <= i_he;
        ht_q <= i_ht;
        vm_q <= i_vm;
        vs_q <= i_vs;
        ve_q <= i_ve;
        vt_q <= i_vt;
      end
      valid_q <= valid_d;
    end
  end

  vidsync_axis #(.NBITS(NBITS)) u_haxis (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_step   (run),
    .i_clear  (!run),
    .i_m      (hm_q),
    .i_s      (hs_q),
    .i_e      (he_q),
    .i_t      (ht_q),
    .o_pos    (h_pos),
    .o_wrap   (h_wrap),
    .o_sync   (h_sync),
    .o_active (h_act)
  );

  vidsync_axis #(.NBITS(NBITS)) u_vaxis (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_step   (run && h_wrap),
    .i_clear  (!run),
    .i_m      (vm_q),
    .i_s      (vs_q),
    .i_e      (ve_q),
    .i_t      (vt_q),
    .o_pos    (v_pos),
    .o_wrap   (v_wrap),
    .o_sync   (v_sync),
    .o_active (v_act)
  );

  always_comb begin
    x_d     = run ? h_pos : '0;
    y_d     = run ? v_pos : '0;
    hsync_d = (run && h_sync) ? HS_ON : ~HS_ON;
    vsync_d = (run && v_sync) ? VS_ON : ~VS_ON;
    de_d    = run && h_act && v_act;
    frame_d = run && (h_pos == '0) && (v_pos == '0);
    err_d   = i_en && !valid_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;
  assign o_de    = de_q;
  assign o_frame = frame_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_vidsyncgen.sv
// tb/tb_vidsyncgen.sv - scoreboard bench for vidsyncgen against a raster-scan reference model
module tb_vidsyncgen;

  typedef struct {
    int hm, hs, he, ht, vm, vs, ve, vt;
  } cfg_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] hm, hs, he, ht, vm, vs, ve, vt;

  logic        hsync, vsync, de, frame, err;
  logic [15:0] ox, oy;
  logic        hsync_n, vsync_n, de_n, frame_n, err_n;
  logic [15:0] ox_n, oy_n;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   armed = 0;

  always #5 clk = ~clk;

  vidsyncgen #(.NBITS(16), .HPOL(1'b1), .VPOL(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en),
    .i_hm(hm), .i_hs(hs), .i_he(he), .i_ht(ht),
    .i_vm(vm), .i_vs(vs), .i_ve(ve), .i_vt(vt),
    .o_hsync(hsync), .o_vsync(vsync), .o_de(de),
    .o_x(ox), .o_y(oy), .o_frame(frame), .o_err(err)
  );

  vidsyncgen #(.NBITS(16), .HPOL(1'b0), .VPOL(1'b0)) dut_n (
    .i_clk(clk), .i_reset(rst), .i_en(en),
    .i_hm(hm), .i_hs(hs), .i_he(he), .i_ht(ht),
    .i_vm(vm), .i_vs(vs), .i_ve(ve), .i_vt(vt),
    .o_hsync(hsync_n), .o_vsync(vsync_n), .o_de(de_n),
    .o_x(ox_n), .o_y(oy_n), .o_frame(frame_n), .o_err(err_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic apply(input cfg_t c);
    hm = 16'(c.hm); hs = 16'(c.hs); he = 16'(c.he); ht = 16'(c.ht);
    vm = 16'(c.vm); vs = 16'(c.vs); ve = 16'(c.ve); vt = 16'(c.vt);
  endtask

  // Raster-order model of one frame; npix<=0 means the whole frame.
  task automatic push_frame(input cfg_t c, input int npix);
    int n = 0;
    int lim = (npix <= 0) ? c.ht * c.vt : npix;
    for (int y = 0; y < c.vt; y++)
      for (int x = 0; x < c.ht; x++)
        if (n < lim) begin
          exp_t e;
          e.x  = 16'(x);
          e.y  = 16'(y);
          e.hs = (x >= c.hs) && (x < c.he);
          e.vs = (y >= c.vs) && (y < c.ve);
          e.de = (x < c.hm) && (y < c.vm);
          e.fr = (x == 0) && (y == 0);
          q.push_back(e);
          n++;
        end
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (q.size() > 0 && n < lim) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout left=%0d want=0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_frame(input string name, input int lim);
    int n = 0;
    bit seen = 0;
    while (!seen && n < lim) begin
      @(negedge clk); #1;
      n++;
      if (frame) seen = 1;
    end
    chk(name, {63'd0, seen}, 64'd1);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_de"}, {63'd0, de}, 64'd0);
    chk({tag, "_hsync"}, {62'd0, hsync, hsync_n}, 64'd1);
    chk({tag, "_vsync"}, {62'd0, vsync, vsync_n}, 64'd1);
    chk({tag, "_xy"}, {32'd0, ox, oy}, 64'd0);
    chk({tag, "_frame"}, {63'd0, frame}, 64'd0);
  endtask

  initial begin
    exp_t e;
    logic [36:0] act, actn;
    forever begin
      @(negedge clk); #1;
      if (!armed && q.size() > 0 && frame) armed = 1;
      if (armed) begin
        if (q.size() == 0) armed = 0;
        else begin
          e = q.pop_front();
          act  = {ox, oy, hsync, vsync, de, frame, err};
          actn = {ox_n, oy_n, ~hsync_n, ~vsync_n, de_n, frame_n, err_n};
          total++;
          if (act !== {e, 1'b0} || actn !== {e, 1'b0}) begin
            bad++;
            $display("FAIL pixel got=%0h got_n=%0h want=%0h", act, actn, {e, 1'b0});
          end
          if (q.size() == 0) armed = 0;
        end
      end
    end
  end

  initial begin
    cfg_t c33, c34, cbad, cr;
    int   n;
    c33 = '{hm:4, hs:5, he:7, ht:9, vm:2, vs:3, ve:4, vt:5};
    c34 = c33; c34.ht = 10;
    cbad = c33; cbad.hs = 3;
    apply(c33);

    repeat (3) @(negedge clk);
    #1;
    idle_checks("reset");
    chk("reset_err", {62'd0, err, err_n}, 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Three back-to-back 45-cycle frames.
    repeat (3) push_frame(c33, 0);
    en = 1'b1;
    wait_drain(200);
    en = 1'b0;
    @(negedge clk); #1;
    idle_checks("stop");

    // Line total changes mid-frame: old frame completes, new one uses 10.
    push_frame(c33, 0);
    push_frame(c34, 0);
    en = 1'b1;
    n = 0;
    while (!(ox == 16'd3 && oy == 16'd1) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("reach_x3y1", {63'd0, n < 100}, 64'd1);
    ht = 16'd10;
    wait_drain(200);
    en = 1'b0;
    apply(c33);
    repeat (3) @(negedge clk);

    // Enable drops at (6,2), then comes back.
    push_frame(c33, 2 * 9 + 7);
    en = 1'b1;
    wait_drain(100);
    en = 1'b0;
    @(negedge clk); #1;
    idle_checks("drop");
    push_frame(c33, 0);
    en = 1'b1;
    @(negedge clk); #1;
    chk("rerun_first", {47'd0, ox, frame}, 64'd1);
    wait_drain(100);
    en = 1'b0;

    // Invalid timing (hm>hs), then corrected.
    apply(cbad);
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("bad_err", {62'd0, err, err_n}, 64'd3);
    idle_checks("bad");
    push_frame(c33, 0);
    apply(c33);
    wait_frame("fix_frame3", 3);
    wait_drain(100);
    chk("fix_err", {63'd0, err}, 64'd0);

    // Asynchronous reset mid-line.
    n = 0;
    while (ox != 16'd3 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    #2 rst = 1'b1;
    #1;
    idle_checks("areset");
    chk("areset_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    push_frame(c33, 0);
    wait_frame("restart_frame3", 3);
    chk("restart_xy", {32'd0, ox, oy}, 64'd0);
    wait_drain(100);
    en = 1'b0;

    // Random timings, two frames each.
    for (int k = 0; k < 6; k++) begin
      cr.ht = int'($urandom_range(20, 6));
      cr.hm = int'($urandom_range(cr.ht - 2, 1));
      cr.hs = int'($urandom_range(cr.ht - 1, cr.hm));
      cr.he = int'($urandom_range(cr.ht, cr.hs + 1));
      cr.vt = int'($urandom_range(8, 3));
      cr.vm = int'($urandom_range(cr.vt - 2, 1));
      cr.vs = int'($urandom_range(cr.vt - 1, cr.vm));
      cr.ve = int'($urandom_range(cr.vt, cr.vs + 1));
      apply(cr);
      repeat (3) @(negedge clk);
      push_frame(cr, 0);
      push_frame(cr, 0);
      en = 1'b1;
      wait_drain(2 * cr.ht * cr.vt + 20);
      en = 1'b0;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vidsyncgen.md
VIDSYNCGEN -- requirements
Module: vidsyncgen

Interface
REQ-001 Parameter NBITS, default 16: width of every timing value and pixel/line coordinate.
REQ-002 Parameter HPOL, default 1: hsync active level.
REQ-003 Parameter VPOL, default 1: vsync active level.
REQ-004 One clock; reset is asynchronous and active-high. Ports i_clk, i_reset.
REQ-005 i_clk  input  1  pixel clock.
REQ-006 i_reset  input  1  asynchronous active-high reset.
REQ-007 i_en  input  1  generator enable.
REQ-008 i_hm, i_hs, i_he, i_ht  input  NBITS each  active width, hsync start, hsync end, line total.
REQ-009 i_vm, i_vs, i_ve, i_vt  input  NBITS each  active height, vsync start, vsync end, frame total (lines).
REQ-010 o_hsync, o_vsync  output  1 each  sync pulses at HPOL/VPOL.
REQ-011 o_de  output  1  data enable, high for active pixels.
REQ-012 o_x, o_y  output  NBITS each  coordinates of the current pixel.
REQ-013 o_frame  output  1  one-cycle pulse on pixel (0,0).
REQ-014 o_err  output  1  shadowed timing is invalid.

Function
REQ-015 Shadow registers SHALL capture all eight timing inputs while i_en=0, while timing is invalid, and on the last pixel of a frame (x=ht-1, y=vt-1); they SHALL NOT change at any other time.
REQ-016 Timing is valid iff 0<hm<=hs<he<=ht and 0<vm<=vs<ve<=vt, evaluated on shadow values and registered (one cycle after capture).
REQ-017 Pixel counter x SHALL count 0..ht-1 and then wrap to 0; line counter y SHALL increment only when x wraps, count 0..vt-1, and then wrap to 0.
REQ-018 When i_en=0 or timing is invalid: x=y=0, o_hsync=!HPOL, o_vsync=!VPOL, o_de=0, o_frame=0.
REQ-019 o_err = invalid flag whenever i_en=1, and 0 whenever i_en=0.
REQ-020 Outputs are registered from the counters with one-cycle latency; o_x/o_y SHALL be the same-cycle counter values as the o_hsync/o_vsync/o_de/o_frame they accompany.
REQ-021 o_hsync is active iff hs<=x<he; o_vsync is active iff vs<=y<ve, and changes only at x=0.
REQ-022 o_de = (x<hm)&&(y<vm).
REQ-023 o_frame = (x==0)&&(y==0)&&enabled&&valid.
REQ-024 When i_en rises with valid timing, the first output cycle SHALL be pixel (0,0) with o_frame=1.
REQ-025 If timing inputs change mid-frame, the current frame SHALL complete on the old values and the new values SHALL apply from the next (0,0).
REQ-026 If i_en falls mid-frame, counters SHALL clear on the next clock with no partial wrap.
REQ-027 All comparisons are unsigned NBITS; no counter may exceed total-1. ht=0 or vt=0 SHALL be treated as invalid.

Reset
REQ-028 On i_reset: x=y=0, shadows=0 (invalid), o_hsync=!HPOL, o_vsync=!VPOL, o_de=0, o_frame=0, o_err=0, o_x=o_y=0.
REQ-029 After reset release, shadows SHALL load on the first clock and counting SHALL begin no later than the third clock if i_en=1 and the inputs are valid.

Structure
REQ-030 No shared package is required; the validity comparison and the polarity constants are local to the module.
REQ-031 One sub-module, vidsync_axis, SHALL be instantiated twice (horizontal and vertical).
REQ-032 vidsync_axis inputs: step enable, clear, m/s/e/t. Outputs: position, wrap, sync, active.

Verification
REQ-033 hm=4, hs=5, he=7, ht=9, vm=2, vs=3, ve=4, vt=5, i_en=1 -> o_frame every 45 cycles; o_hsync high at x=5,6; o_vsync high for all of line 3; o_de high for 8 cycles per frame.
REQ-034 Same timing; change i_ht to 10 at x=3,y=1 -> current frame stays 45 cycles, next frame is 50 cycles.
REQ-035 hs=3 with hm=4 (hm>hs) -> o_err=1, outputs idle, x=y=0; correct hs to 5 -> o_err=0 and o_frame within 3 cycles.
REQ-036 Drop i_en at x=6,y=2 -> next cycle o_de=0, syncs inactive; re-raise i_en -> first output is (0,0) with o_frame=1.
REQ-037 Assert i_reset asynchronously mid-line (between clock edges) -> all outputs reach reset values immediately; after release, counting restarts from (0,0).
REQ-038 HPOL=0, VPOL=0 with the REQ-033 timing -> syncs idle high and pulse low at the same positions.
